// File: rtl/axil_wr_master.sv
// axil_wr_master: turns single-word write commands into AXI4-Lite AW/W/B transactions with per-phase timeout
module axil_wr_master #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0]    cmd_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [1:0]               rsp_resp,
  output logic                     rsp_timeout,
  output logic                     busy,
  output logic [ADDRESS_WIDTH-1:0] m_axi_awaddr,
  output logic                     m_axi_awvalid,
  input  logic                     m_axi_awready,
  output logic [DATA_WIDTH-1:0]    m_axi_wdata,
  output logic                     m_axi_wvalid,
  input  logic                     m_axi_wready,
  input  logic [1:0]               m_axi_bresp,
  input  logic                     m_axi_bvalid,
  output logic                     m_axi_bready
);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, DONE} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic ph, hs, to;
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign m_axi_awvalid = state == ADDR;
  assign m_axi_wvalid = state == DATA;
  assign m_axi_bready = state == RESP;
  assign rsp_valid = state == DONE;
  // phase handshake detection, timeout and next state; a handshake on the last cycle beats the timeout
  always_comb begin
    ph = state == ADDR || state == DATA || state == RESP;
    hs = (state == ADDR && m_axi_awready) || (state == DATA && m_axi_wready) || (state == RESP && m_axi_bvalid);
    to = ph && !hs && cnt == TMAX;
    state_nxt = state;
    case (state)
      IDLE: state_nxt = cmd_valid ? ADDR : IDLE;
      ADDR: state_nxt = m_axi_awready ? DATA : (to ? DONE : ADDR);
      DATA: state_nxt = m_axi_wready ? RESP : (to ? DONE : DATA);
      RESP: state_nxt = (m_axi_bvalid || to) ? DONE : RESP;
      DONE: state_nxt = rsp_ready ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // phase counter restarts on every state change; command latch; response capture
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      m_axi_awaddr <= '0;
      m_axi_wdata <= '0;
      rsp_resp <= 2'b00;
      rsp_timeout <= 1'b0;
    end else begin
      cnt <= (state_nxt != state) ? '0 : (ph ? cnt + 1'b1 : cnt);
      if (state == IDLE && cmd_valid) begin
        m_axi_awaddr <= cmd_addr;
        m_axi_wdata <= cmd_data;
      end
      if (state == RESP && m_axi_bvalid) {rsp_resp, rsp_timeout} <= {m_axi_bresp, 1'b0};
      else if (to) {rsp_resp, rsp_timeout} <= {2'b10, 1'b1};
    end
endmodule

// File: tb/tb_axil_wr_master.sv
// tb_axil_wr_master: table-driven and randomized checks of axil_wr_master against a register-slave model
module tb_axil_wr_master;
  localparam int T = 16;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready, rsp_valid, rsp_ready = 0, rsp_timeout, busy;
  logic [31:0] cmd_addr = 0, cmd_data = 0, awaddr, wdata;
  logic [1:0] rsp_resp, bresp;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  axil_wr_master #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout), .busy(busy), .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready));
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] addr, data;
    bit aw_en;
    int aw_dly, w_dly, b_dly, hold;
    logic [1:0] resp;
    bit to;
    int lat, aw_cyc;
    bit w_seen;
    logic [31:0] reg_v;
  } vec_t;
  int pass_cnt = 0, total = 0;
  bit aw_en = 1;
  int aw_dly = 0, w_dly = 0, b_dly = 0;
  logic [31:0] output_reg, addr_q;
  int aw_cnt, w_cnt, b_cnt;
  bit pend;
  int aw_tot = 0, w_tot = 0, viol = 0;
  logic pwv = 0;
  logic [31:0] pwd = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask
  // register slave: offset 0 is output_reg (OKAY), anything else answers SLVERR without writing
  initial begin
    awready = 0; wready = 0; bvalid = 0; bresp = 0; output_reg = 0; addr_q = 0;
    pend = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        awready = 0; wready = 0; bvalid = 0; pend = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      end else begin
        aw_cnt = awvalid ? aw_cnt + 1 : 0;
        awready = aw_en && aw_cnt > aw_dly;
        if (awvalid && awready) begin addr_q = awaddr; pend = 0; end
        bvalid = 0;
        if (pend) begin
          b_cnt++;
          bvalid = b_cnt > b_dly;
          if (bvalid && bready) pend = 0;
        end
        w_cnt = wvalid ? w_cnt + 1 : 0;
        wready = w_cnt > w_dly;
        if (wvalid && wready) begin
          if (addr_q == 0) output_reg = wdata;
          bresp = addr_q == 0 ? 2'b00 : 2'b10;
          pend = 1;
          b_cnt = 0;
        end
      end
    end
  end
  // protocol monitor: AW/W never together, wdata stable while wvalid held
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (awvalid) aw_tot++;
      if (wvalid) w_tot++;
      if (awvalid && wvalid) viol++;
      if (wvalid && pwv && wdata !== pwd) viol++;
    end
    pwv = wvalid;
    pwd = wdata;
  end
  // reference: each phase costs min(delay+1, T) cycles and completes only if delay+1 <= T
  function automatic vec_t model(input logic [31:0] a, d, input int awd, wd, bd, h, input logic [31:0] reg_in);
    vec_t m;
    m.addr = a; m.data = d; m.aw_en = 1; m.aw_dly = awd; m.w_dly = wd; m.b_dly = bd; m.hold = h;
    m.reg_v = reg_in; m.to = 1; m.resp = 2'b10; m.w_seen = 0;
    m.aw_cyc = awd + 1 > T ? T : awd + 1;
    m.lat = m.aw_cyc;
    if (awd + 1 <= T) begin
      m.w_seen = 1;
      m.lat += wd + 1 > T ? T : wd + 1;
      if (wd + 1 <= T) begin
        if (a == 0) m.reg_v = d;
        m.lat += bd + 1 > T ? T : bd + 1;
        if (bd + 1 <= T) begin
          m.to = 0;
          m.resp = a == 0 ? 2'b00 : 2'b10;
        end
      end
    end
    m.lat += 1;
    return m;
  endfunction
  task automatic do_txn(input vec_t v, input bit nv, input logic [31:0] na, nd);
    int n, lat, a0, w0;
    aw_en = v.aw_en; aw_dly = v.aw_dly; w_dly = v.w_dly; b_dly = v.b_dly;
    cmd_addr = v.addr; cmd_data = v.data; cmd_valid = 1; rsp_ready = 0;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    chk("accept", cmd_ready, 1);
    a0 = aw_tot; w0 = w_tot;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
    lat = 0;
    while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
    chk("latency", lat + 1, v.lat);
    chk("rsp_resp", rsp_resp, v.resp);
    chk("rsp_timeout", rsp_timeout, v.to);
    chk("busy", busy, 1);
    chk("aw_cycles", aw_tot - a0, v.aw_cyc);
    chk("w_seen", w_tot != w0, v.w_seen);
    if (nv) begin cmd_addr = na; cmd_data = nd; cmd_valid = 1; end
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_resp", rsp_resp, v.resp);
      chk("hold_rsp_timeout", rsp_timeout, v.to);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("cmd_ready_after", cmd_ready, 1);
    chk("rsp_valid_after", rsp_valid, 0);
    chk("output_reg", output_reg, v.reg_v);
  endtask
  initial begin
    vec_t tbl[5];
    vec_t m;
    logic [31:0] exp_reg;
    int n, awd, wd, bd;
    tbl[0] = '{32'h0, 32'd100, 1, 0, 0, 0, 0, 2'b00, 0, 4, 1, 1, 32'd100};
    tbl[1] = '{32'h4, 32'd500, 1, 0, 0, 0, 5, 2'b10, 0, 4, 1, 1, 32'd100};
    tbl[2] = '{32'h0, 32'd250, 1, 0, 0, 0, 0, 2'b00, 0, 4, 1, 1, 32'd250};
    tbl[3] = '{32'h0, 32'h33, 0, 0, 0, 0, 0, 2'b10, 1, 17, 16, 0, 32'd250};
    tbl[4] = '{32'h0, 32'd750, 1, 0, 3, 2, 0, 2'b00, 0, 9, 1, 1, 32'd750};
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) do_txn(tbl[i], i == 1, tbl[2].addr, tbl[2].data);
    aw_en = 1; aw_dly = 0; w_dly = 6; b_dly = 0;
    cmd_addr = 32'h4; cmd_data = 32'd999; cmd_valid = 1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
    n = 0;
    while (!wvalid && n < 50) begin @(negedge clk); n++; end
    chk("mid_data_wvalid", wvalid, 1);
    rst = 1;
    #1;
    chk("arst_cmd_ready", cmd_ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_awvalid", awvalid, 0);
    chk("arst_wvalid", wvalid, 0);
    chk("arst_bready", bready, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_rsp_timeout", rsp_timeout, 0);
    chk("arst_rsp_resp", rsp_resp, 0);
    chk("arst_awaddr", awaddr, 0);
    chk("arst_wdata", wdata, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    chk("abort_no_write", output_reg, 32'd750);
    @(negedge clk);
    m = model(32'h0, 32'd42, 0, 0, 0, 0, 32'd750);
    do_txn(m, 0, 0, 0);
    exp_reg = m.reg_v;
    for (int i = 0; i < 40; i++) begin
      awd = $urandom_range(0, 7) == 0 ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 3));
      wd = $urandom_range(0, 7) == 0 ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 3));
      bd = $urandom_range(0, 7) == 0 ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 3));
      m = model($urandom_range(0, 1) ? 32'h4 : 32'h0, $urandom, awd, wd, bd, $urandom_range(0, 3), exp_reg);
      do_txn(m, 0, 0, 0);
      exp_reg = m.reg_v;
    end
    chk("protocol_violations", viol, 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
